// File: rtl/radix4_booth_accumulator_pkg.sv
// Shared definitions for the radix-4 Booth partial-product accumulator:
// FSM state encoding and the digit-count/counter-width derivations.
package radix4_booth_accumulator_pkg;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_OUTPUT = 1'b1
    } state_e;

    // Maximum number of radix-4 digits (partial products) for a multiplicand of width w.
    function automatic int npp_f(input int w);
        return w / 2;
    endfunction

    // Counter must also hold NPP itself, since prod_ndig reports the digit count.
    function automatic int ndig_w_f(input int w);
        return $clog2(w / 2 + 1);
    endfunction

endpackage

// File: rtl/radix4_booth_accumulator_if.sv
// Partial-product input stream and product output stream of the Booth accumulator.
interface radix4_booth_accumulator_if #(parameter int width = 8);
    import radix4_booth_accumulator_pkg::*;

    localparam int NDW = ndig_w_f(width);

    logic                 pp_valid;
    logic                 pp_ready;
    logic [width:0]       pp_gen;
    logic                 pp_sign;
    logic                 pp_last;
    logic                 prod_valid;
    logic                 prod_ready;
    logic [2*width-1:0]   prod;
    logic [NDW-1:0]       prod_ndig;

    modport master (
        output pp_valid, pp_gen, pp_sign, pp_last, prod_ready,
        input  pp_ready, prod_valid, prod, prod_ndig
    );

    modport slave (
        input  pp_valid, pp_gen, pp_sign, pp_last, prod_ready,
        output pp_ready, prod_valid, prod, prod_ndig
    );

endinterface

// File: rtl/radix4_booth_accumulator_pp_align.sv
// Sign-extends one Booth partial product plus its +1 correction to the product
// width and shifts it to the weight of its digit position (4^index).
module booth_pp_align
    import radix4_booth_accumulator_pkg::*;
#(
    parameter int width = 8
) (
    input  logic [width:0]               pp_gen,
    input  logic                         pp_sign,
    input  logic [ndig_w_f(width)-1:0]   index,
    output logic [2*width-1:0]           aligned
);

    localparam int PW = 2 * width;

    logic [PW-1:0] pp_ext;

    assign pp_ext  = {{(width - 1){pp_gen[width]}}, pp_gen} + PW'(pp_sign);
    assign aligned = pp_ext << {index, 1'b0};

endmodule

// File: rtl/radix4_booth_accumulator.sv
// Accumulates up to NPP radix-4 Booth partial products into one 2*width product.
//   state     | meaning
//   ST_ACCUM  | pp_ready=1, absorbing partial products into acc
//   ST_OUTPUT | prod_valid=1, acc/count held until the consumer takes them
module radix4_booth_accumulator
    import radix4_booth_accumulator_pkg::*;
#(
    parameter int width = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    radix4_booth_accumulator_if.slave    bus
);

    localparam int NPP = npp_f(width);
    localparam int NDW = ndig_w_f(width);
    localparam int PW  = 2 * width;
    localparam logic [NDW-1:0] LAST_IDX = NDW'(NPP - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [NDW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]   pp_aligned;

    booth_pp_align #(.width(width)) u_align (
        .pp_gen  (bus.pp_gen),
        .pp_sign (bus.pp_sign),
        .index   (cnt_q),
        .aligned (pp_aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (state_q == ST_ACCUM) begin
            if (bus.pp_valid) begin
                acc_d = acc_q + pp_aligned;
                cnt_d = cnt_q + NDW'(1);
                if (bus.pp_last || (cnt_q == LAST_IDX)) begin
                    state_d = ST_OUTPUT;
                end
            end
        end else begin
            if (bus.prod_ready) begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_ACCUM;
            end
        end
    end

    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    assign bus.pp_ready   = (state_q == ST_ACCUM);
    assign bus.prod_valid = (state_q == ST_OUTPUT);
    assign bus.prod       = acc_q;
    assign bus.prod_ndig  = cnt_q;

endmodule

// File: tb/tb_radix4_booth_accumulator.sv
// Scoreboard bench for radix4_booth_accumulator: directed corner cases followed by
// randomized products checked against an arithmetic model of the Booth digit sum.
module tb_radix4_booth_accumulator;

    localparam int W   = 8;
    localparam int NPP = W / 2;
    localparam int PW  = 2 * W;

    typedef logic [W:0] pp_t;
    typedef struct {
        logic [PW-1:0] prod;
        int            ndig;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    radix4_booth_accumulator_if #(.width(W)) bus ();

    radix4_booth_accumulator #(.width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_run  = 0;
    int   n_fail = 0;
    bit   rdy_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Value of one digit at position i: (signed pp + correction) * 4^i, modulo 2^PW.
    function automatic logic [PW-1:0] term(input pp_t g, input logic s, input int i);
        longint v;
        v = longint'($signed(g)) + longint'(s);
        return PW'(v * (longint'(1) << (2 * i)));
    endfunction

    // Monitor: every product the consumer takes is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.prod_valid && bus.prod_ready) begin
            if (sb_q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_product: got %0h expected none", bus.prod);
            end else begin
                mon_e = sb_q.pop_front();
                check("prod", 64'(bus.prod), 64'(mon_e.prod));
                check("prod_ndig", 64'(bus.prod_ndig), 64'(mon_e.ndig));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) bus.prod_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input pp_t g, input logic s, input logic l, output int waits);
        bit acc;
        waits        = 0;
        bus.pp_valid = 1'b1;
        bus.pp_gen   = g;
        bus.pp_sign  = s;
        bus.pp_last  = l;
        forever begin
            @(negedge clk);
            acc = bus.pp_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits >= 300) begin
                n_run++;
                n_fail++;
                $display("FAIL send_timeout: got no acceptance expected pp_ready within 300 cycles");
                break;
            end
        end
        bus.pp_valid = 1'b0;
        bus.pp_gen   = pp_t'($urandom);
        bus.pp_sign  = 1'($urandom);
        bus.pp_last  = 1'($urandom);
    endtask

    task automatic send_product(input int n, input int max_gap, output int first_waits);
        logic [PW-1:0] e;
        pp_t           g;
        logic          s, l;
        int            w;
        e = '0;
        first_waits = 0;
        for (int i = 0; i < n; i++) begin
            g = pp_t'($urandom);
            s = 1'($urandom);
            if (i == n - 1) l = (n < NPP) ? 1'b1 : 1'($urandom);
            else            l = 1'b0;
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send(g, s, l, w);
            if (i == 0) first_waits = w;
            e = e + term(g, s, i);
        end
        sb_q.push_back('{e, n});
    endtask

    initial begin
        int w, fw, t;

        bus.pp_valid   = 1'b0;
        bus.pp_gen     = '0;
        bus.pp_sign    = 1'b0;
        bus.pp_last    = 1'b0;
        bus.prod_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_prod_valid", 64'(bus.prod_valid), 64'd0);
        check("rst_prod", 64'(bus.prod), 64'd0);
        check("rst_prod_ndig", 64'(bus.prod_ndig), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_pp_ready", 64'(bus.pp_ready), 64'd1);
        @(posedge clk);
        #1;

        // Four digits with last on the 4th, then a 5-cycle hold with pp_valid asserted
        bus.prod_ready = 1'b0;
        send(9'h003, 1'b0, 1'b0, w);
        send(9'h003, 1'b0, 1'b0, w);
        send(9'h000, 1'b0, 1'b0, w);
        send(9'h000, 1'b0, 1'b1, w);
        sb_q.push_back('{16'h000F, 4});
        bus.pp_valid = 1'b1;
        bus.pp_gen   = 9'h0AA;
        bus.pp_sign  = 1'b1;
        bus.pp_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_prod_valid", 64'(bus.prod_valid), 64'd1);
            check("hold_pp_ready", 64'(bus.pp_ready), 64'd0);
            check("hold_prod", 64'(bus.prod), 64'h000F);
            check("hold_prod_ndig", 64'(bus.prod_ndig), 64'd4);
            @(posedge clk);
            #1;
        end
        bus.prod_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.pp_valid   = 1'b0;
        bus.prod_ready = 1'b0;
        @(negedge clk);
        check("release_pp_ready", 64'(bus.pp_ready), 64'd1);
        check("release_prod_valid", 64'(bus.prod_valid), 64'd0);
        check("release_acc_cleared", 64'(bus.prod), 64'd0);
        @(posedge clk);
        #1;

        // Single negative digit with correction
        bus.prod_ready = 1'b1;
        send(9'h1FC, 1'b1, 1'b1, w);
        sb_q.push_back('{16'hFFFD, 1});

        // Forced termination after NPP digits without pp_last
        for (int k = 0; k < NPP; k++) send(9'h001, 1'b0, 1'b0, w);
        sb_q.push_back('{16'h0055, 4});
        @(negedge clk);
        check("forced_term_pp_ready", 64'(bus.pp_ready), 64'd0);
        @(posedge clk);
        #1;

        // Reset mid-product discards partial state
        send(9'h005, 1'b0, 1'b0, w);
        send(9'h003, 1'b1, 1'b0, w);
        rst_n = 1'b0;
        #1;
        check("midrst_prod", 64'(bus.prod), 64'd0);
        check("midrst_prod_valid", 64'(bus.prod_valid), 64'd0);
        check("midrst_prod_ndig", 64'(bus.prod_ndig), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(9'h002, 1'b0, 1'b1, w);
        sb_q.push_back('{16'h0002, 1});

        // Back-to-back products: exactly one OUTPUT cycle between them
        idle(2);
        send_product($urandom_range(1, NPP), 0, fw);
        for (int k = 0; k < 6; k++) begin
            send_product($urandom_range(1, NPP), 0, fw);
            check("b2b_gap", 64'(fw), 64'd1);
        end

        // Randomized products with idle gaps and consumer back-pressure
        rdy_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send_product($urandom_range(1, NPP), 2, fw);
        end
        rdy_rand = 1'b0;
        bus.prod_ready = 1'b1;
        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/radix4_booth_accumulator.md
RADIX4_BOOTH_ACCUMULATOR -- requirements
Module: radix4_booth_accumulator

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the multiplicand width; width SHALL be even and >= 4.
REQ-002 The block SHALL use the derived constant NPP = width/2, the maximum number of partial products per product.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pp_valid  input  1  partial product present on pp_gen/pp_sign/pp_last.
REQ-006 pp_ready  output  1  block accepts a partial product this cycle.
REQ-007 pp_gen  input  width+1  signed partial product from the radix-4 Booth generator.
REQ-008 pp_sign  input  1  +1 LSB correction belonging to pp_gen.
REQ-009 pp_last  input  1  this partial product is the final one of the current product.
REQ-010 prod_valid  output  1  prod holds a completed product.
REQ-011 prod_ready  input  1  consumer takes prod this cycle.
REQ-012 prod  output  2*width  two's-complement product.
REQ-013 prod_ndig  output  clog2(NPP+1)  number of partial products summed into prod.

Function
REQ-014 States: ACCUM (pp_ready=1, prod_valid=0) and OUTPUT (pp_ready=0, prod_valid=1); no other states.
REQ-015 A partial product is accepted when pp_valid && pp_ready; index i is the count of earlier accepted partial products in the current product, starting at 0.
REQ-016 On acceptance acc SHALL become acc + ((signext(pp_gen) + pp_sign) << 2*i), modulo 2^(2*width).
REQ-017 Acceptance with pp_last=1 or i=NPP-1 SHALL move to OUTPUT next cycle; prod and prod_ndig (= i+1) SHALL be valid one cycle after the final acceptance.
REQ-018 Early pp_last (i < NPP-1) SHALL treat the remaining digits as zero; pp_last at i=NPP-1 has no additional effect.
REQ-019 In OUTPUT, prod and prod_ndig SHALL hold stable while prod_ready=0.
REQ-020 prod_valid && prod_ready SHALL clear acc and the digit counter and return to ACCUM next cycle; no partial product is accepted in that same cycle.
REQ-021 pp_gen/pp_sign/pp_last SHALL be ignored whenever pp_valid=0 or pp_ready=0.
REQ-022 No combinational path SHALL exist from any input to pp_ready or prod_valid.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately force ACCUM, acc=0, counter=0, prod=0, prod_ndig=0, prod_valid=0, and pp_ready=1 once reset is released.
REQ-024 Reset asserted mid-product or in OUTPUT SHALL discard all partial state; the first acceptance after reset has index 0.

Structure
REQ-025 The state encoding and the NPP/counter-width derivation SHALL reside in the shared multiplier package.
REQ-026 The shift-and-sign-extend of one partial product to 2*width bits SHALL be a sub-module named booth_pp_align (combinational; inputs pp_gen, pp_sign, index).

Verification (width=8)
REQ-027 pp_gen=9'h003/sign0, 9'h003/sign0, 9'h000, 9'h000 (last on 4th) -> prod=16'h000F, prod_ndig=4, prod_valid 1 cycle after 4th acceptance.
REQ-028 pp_gen=9'h1FC, pp_sign=1, pp_last=1 as the sole digit -> prod=16'hFFFD, prod_ndig=1.
REQ-029 Four digits 9'h001, none with pp_last -> forced termination after the 4th, prod=16'h0055, and pp_ready=0 on the next cycle.
REQ-030 Hold prod_ready=0 for 5 cycles in OUTPUT while driving pp_valid=1 -> prod unchanged, pp_ready=0, no digit absorbed; release -> ACCUM the next cycle with acc=0.
REQ-031 Assert rst_n=0 after 2 accepted digits, release, then send 9'h002 with last -> prod=16'h0002, prod_ndig=1.
REQ-032 Back-to-back products with prod_ready held at 1 -> every product is correct, and there is exactly one OUTPUT cycle between products.
